// File: rtl/serial_word_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits LSB-first,
// optional parity bit, stop bit, each held CLKS_PER_BIT clocks on txd.
module serial_word_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             txd,
   output logic             busy,
   output logic             done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    clk_cnt, clk_cnt_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic             par_bit, par_nxt;
   logic             bit_end;
   logic             txd_nxt, busy_nxt, done_nxt;

   assign din_ready = (state == S_IDLE) & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         txd     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         clk_cnt <= clk_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         par_bit <= par_nxt;
         txd     <= txd_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

   // With CLKS_PER_BIT=1 bit_end is always true, so clk_cnt stays at zero.
   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      par_nxt     = par_bit;
      bit_end     = (clk_cnt == CLK_LAST);
      if (state != S_IDLE)
         clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
      case (state)
         S_IDLE: begin
            clk_cnt_nxt = '0;
            if (din_valid && din_ready) begin
               state_nxt   = S_START;
               shreg_nxt   = din;
               bit_cnt_nxt = '0;
               par_nxt     = (PARITY == 2) ? ~^din : ^din;
            end
         end
         S_START:
            if (bit_end) state_nxt = S_DATA;
         S_DATA:
            if (bit_end) begin
               shreg_nxt = shreg >> 1;
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         S_PARITY:
            if (bit_end) state_nxt = S_STOP;
         S_STOP:
            if (bit_end) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state and registered, keeping txd glitch-free.
   always_comb begin
      txd_nxt  = 1'b1;
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_STOP) && (clk_cnt_nxt == CLK_LAST);
      case (state_nxt)
         S_START:  txd_nxt = 1'b0;
         S_DATA:   txd_nxt = shreg_nxt[0];
         S_PARITY: txd_nxt = par_nxt;
         default:  txd_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: four instances cover no/even/odd parity
// and single-clock bits; expected line states are queued at acceptance.
module tb_serial_word_tx;

   typedef struct packed {
      logic txd;
      logic busy;
      logic done;
   } exp_t;

   logic            clk = 1'b0;
   logic [3:0]      rst;
   logic [3:0]      val;
   logic [3:0][7:0] din;
   wire  [3:0]      tx, bsy, dn, rdy;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   serial_word_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0)) u0 (
      .clk(clk), .rst(rst[0]), .din(din[0]), .din_valid(val[0]),
      .din_ready(rdy[0]), .txd(tx[0]), .busy(bsy[0]), .done(dn[0]));
   serial_word_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1)) u1 (
      .clk(clk), .rst(rst[1]), .din(din[1]), .din_valid(val[1]),
      .din_ready(rdy[1]), .txd(tx[1]), .busy(bsy[1]), .done(dn[1]));
   serial_word_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2)) u2 (
      .clk(clk), .rst(rst[2]), .din(din[2]), .din_valid(val[2]),
      .din_ready(rdy[2]), .txd(tx[2]), .busy(bsy[2]), .done(dn[2]));
   serial_word_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY(0)) u3 (
      .clk(clk), .rst(rst[3]), .din(din[3]), .din_valid(val[3]),
      .din_ready(rdy[3]), .txd(tx[3]), .busy(bsy[3]), .done(dn[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: start, LSB-first data, optional parity, stop.
   task automatic push_frame(input logic [7:0] w, input int par, input int cpb);
      logic b[$];
      logic p;
      exp_t e;
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(w[i]);
      if (par != 0) begin
         p = 1'b0;
         for (int i = 0; i < 8; i++) p = p ^ w[i];
         if (par == 2) p = ~p;
         b.push_back(p);
      end
      b.push_back(1'b1);
      for (int k = 0; k < b.size(); k++)
         for (int c = 0; c < cpb; c++) begin
            e.txd  = b[k];
            e.busy = 1'b1;
            e.done = (k == b.size() - 1) && (c == cpb - 1);
            q.push_back(e);
         end
   endtask

   task automatic xmit(input int idx, input logic [7:0] w, input int par, input int cpb,
                       input int poke_at, input int abort_at, input bit hold,
                       input logic [7:0] next_w);
      exp_t e;
      int   n;
      din[idx] = w;
      val[idx] = 1'b1;
      chk("ready_before", rdy[idx], 1);
      @(posedge clk);
      push_frame(w, par, cpb);
      @(negedge clk);
      if (hold) din[idx] = next_w;
      else      val[idx] = 1'b0;
      n = q.size();
      for (int i = 1; i <= n; i++) begin
         if (i == abort_at) begin
            rst[idx] = 1'b1;
            #1;
            chk("abort_txd", tx[idx], 1);
            chk("abort_busy", bsy[idx], 0);
            chk("abort_done", dn[idx], 0);
            chk("abort_ready", rdy[idx], 0);
            q.delete();
            repeat (2) begin
               @(negedge clk);
               chk("abort_no_done", dn[idx], 0);
            end
            rst[idx] = 1'b0;
            #1;
            chk("abort_ready_after", rdy[idx], 1);
            chk("abort_busy_after", bsy[idx], 0);
            return;
         end
         if (i == poke_at) begin
            din[idx] = ~w;
            val[idx] = 1'b1;
         end else if (!hold) begin
            val[idx] = 1'b0;
         end
         e = q.pop_front();
         chk($sformatf("txd_c%0d", i), tx[idx], e.txd);
         chk($sformatf("busy_c%0d", i), bsy[idx], e.busy);
         chk($sformatf("done_c%0d", i), dn[idx], e.done);
         chk($sformatf("ready_c%0d", i), rdy[idx], 0);
         @(negedge clk);
      end
      chk("idle_txd", tx[idx], 1);
      chk("idle_busy", bsy[idx], 0);
      chk("idle_done", dn[idx], 0);
      chk("idle_ready", rdy[idx], 1);
   endtask

   initial begin
      rst = '1;
      val = '0;
      din = '0;
      #1;
      for (int d = 0; d < 4; d++) begin
         chk("rst_txd", tx[d], 1);
         chk("rst_busy", bsy[d], 0);
         chk("rst_done", dn[d], 0);
         chk("rst_ready", rdy[d], 0);
      end
      // Valid while in reset must not start a frame.
      din[0] = 8'h77;
      val[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstvalid_busy", bsy[0], 0);
      chk("rstvalid_txd", tx[0], 1);
      val[0] = 1'b0;
      rst = '0;
      #1;
      for (int d = 0; d < 4; d++) chk("release_ready", rdy[d], 1);
      @(negedge clk);
      chk("rstvalid_not_taken", bsy[0], 0);

      xmit(0, 8'hA5, 0, 4, -1, -1, 1'b0, 8'h00);
      xmit(1, 8'hA5, 1, 4, -1, -1, 1'b0, 8'h00);
      xmit(2, 8'hA5, 2, 4, -1, -1, 1'b0, 8'h00);
      xmit(0, 8'h00, 0, 4, -1, -1, 1'b1, 8'hFF);
      xmit(0, 8'hFF, 0, 4, -1, -1, 1'b0, 8'h00);
      xmit(0, 8'h5A, 0, 4, 10, -1, 1'b0, 8'h00);
      xmit(0, 8'hC3, 0, 4, -1, 17, 1'b0, 8'h00);
      xmit(0, 8'h3C, 0, 4, -1, -1, 1'b0, 8'h00);
      xmit(3, 8'h81, 0, 1, -1, -1, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
